// File: rtl/decoder_seq_pkg.sv
// Shared types and constants for the JP / JP cc / OUT (n),A / IN A,(n) sequencer.
package decoder_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_LO,
    ST_FETCH_HI,
    ST_EXEC,
    ST_IO_WAIT,
    ST_IO_XFER
  } state_t;

  typedef enum logic [1:0] {
    OP_JP,
    OP_JPCC,
    OP_OUT,
    OP_IN
  } op_kind_t;

  localparam logic [2:0] CC_NZ = 3'd0;
  localparam logic [2:0] CC_Z  = 3'd1;
  localparam logic [2:0] CC_NC = 3'd2;
  localparam logic [2:0] CC_C  = 3'd3;
  localparam logic [2:0] CC_PO = 3'd4;
  localparam logic [2:0] CC_PE = 3'd5;
  localparam logic [2:0] CC_P  = 3'd6;
  localparam logic [2:0] CC_M  = 3'd7;

  localparam int S_BIT  = 7;
  localparam int Z_BIT  = 6;
  localparam int PV_BIT = 2;
  localparam int C_BIT  = 0;

  // 11xxx01x selects the group
  localparam logic [7:0] GROUP_MASK  = 8'hC6;
  localparam logic [7:0] GROUP_MATCH = 8'hC2;

  function automatic logic in_group(input logic [7:0] src);
    return (src & GROUP_MASK) == GROUP_MATCH;
  endfunction

  function automatic op_kind_t decode_kind(input logic [7:0] src);
    if (!src[0])     return OP_JPCC;
    else if (!src[4]) return OP_JP;
    else if (src[3])  return OP_IN;
    else              return OP_OUT;
  endfunction

endpackage

// File: rtl/decoder_cc_eval.sv
// Combinational condition-code evaluation against the F register.
module decoder_cc_eval
  import decoder_seq_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [7:0] flags,
  output logic       taken
);

  logic unused_flags;
  assign unused_flags = ^{flags[5:3], flags[1]};

  always_comb begin
    taken = 1'b0;
    unique case (ccc)
      CC_NZ:   taken = ~flags[Z_BIT];
      CC_Z:    taken =  flags[Z_BIT];
      CC_NC:   taken = ~flags[C_BIT];
      CC_C:    taken =  flags[C_BIT];
      CC_PO:   taken = ~flags[PV_BIT];
      CC_PE:   taken =  flags[PV_BIT];
      CC_P:    taken = ~flags[S_BIT];
      CC_M:    taken =  flags[S_BIT];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decoder_seq_jp_io.sv
// Sequenced controller for JP nn, JP cc,nn, OUT (n),A and IN A,(n).
//  state       | meaning
//  ST_IDLE     | waiting for an opcode strobe
//  ST_FETCH_LO | fetching operand low byte (n for I/O)
//  ST_FETCH_HI | fetching operand high byte (jumps only)
//  ST_EXEC     | evaluate condition, load PC, complete
//  ST_IO_WAIT  | counting wait cycles before the I/O transfer
//  ST_IO_XFER  | I/O read or write until busReady
module decoder_seq_jp_io
  import decoder_seq_pkg::*;
#(
  parameter int IO_WAIT   = 1,
  parameter bit ENABLE_IO = 1'b1
) (
  input  logic        clk,
  input  logic        notReset,
  input  logic        enable,
  input  logic [7:0]  Source,
  input  logic [7:0]  flags,
  input  logic [7:0]  accIn,
  input  logic [7:0]  dataIn,
  input  logic        busReady,
  output logic        busy,
  output logic        memRead,
  output logic        pcInc,
  output logic        ioRead,
  output logic        ioWrite,
  output logic [15:0] portAddr,
  output logic [7:0]  ioData,
  output logic        accLoad,
  output logic [7:0]  accValue,
  output logic        pcLoad,
  output logic [15:0] pcLoadValue,
  output logic        done,
  output logic        unsupported
);

  localparam logic [3:0] WAIT_LOAD = (IO_WAIT > 0) ? 4'(IO_WAIT - 1) : 4'd0;

  state_t     state_q, state_d;
  op_kind_t   op_q;
  logic [2:0] ccc_q;
  logic [7:0] lo_q, hi_q;
  logic [3:0] cnt_q;
  logic       cc_taken;
  logic       src_is_jump;
  logic       accept;

  decoder_cc_eval u_cc_eval (
    .ccc   (ccc_q),
    .flags (flags),
    .taken (cc_taken)
  );

  assign src_is_jump = (decode_kind(Source) == OP_JP) || (decode_kind(Source) == OP_JPCC);
  assign accept      = in_group(Source) && (src_is_jump || ENABLE_IO);

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_JP;
      ccc_q   <= 3'd0;
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (enable && accept) begin
            op_q  <= decode_kind(Source);
            ccc_q <= Source[5:3];
          end
        end
        ST_FETCH_LO: begin
          if (busReady) begin
            lo_q  <= dataIn;
            cnt_q <= WAIT_LOAD;
          end
        end
        ST_FETCH_HI: begin
          if (busReady) hi_q <= dataIn;
        end
        ST_IO_WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    memRead     = 1'b0;
    ioRead      = 1'b0;
    ioWrite     = 1'b0;
    portAddr    = 16'd0;
    ioData      = 8'd0;
    accLoad     = 1'b0;
    accValue    = 8'd0;
    pcLoad      = 1'b0;
    done        = 1'b0;
    unsupported = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable) begin
          if (accept) state_d = ST_FETCH_LO;
          // the only output not derived from state, so reset must gate it
          else unsupported = notReset;
        end
      end
      ST_FETCH_LO: begin
        memRead = 1'b1;
        if (busReady) begin
          if (op_q == OP_JP || op_q == OP_JPCC) state_d = ST_FETCH_HI;
          else if (IO_WAIT == 0)                 state_d = ST_IO_XFER;
          else                                   state_d = ST_IO_WAIT;
        end
      end
      ST_FETCH_HI: begin
        memRead = 1'b1;
        if (busReady) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        done    = 1'b1;
        pcLoad  = (op_q == OP_JP) || cc_taken;
        state_d = ST_IDLE;
      end
      ST_IO_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IO_XFER;
      end
      ST_IO_XFER: begin
        ioRead   = (op_q == OP_IN);
        ioWrite  = (op_q == OP_OUT);
        portAddr = {accIn, lo_q};
        ioData   = (op_q == OP_OUT) ? accIn : 8'd0;
        if (busReady) begin
          done     = 1'b1;
          accLoad  = (op_q == OP_IN);
          accValue = (op_q == OP_IN) ? dataIn : 8'd0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pcInc       = memRead & busReady;
  assign pcLoadValue = {hi_q, lo_q};

endmodule

// File: tb/tb_decoder_seq_jp_io.sv
// Randomized and directed checks of decoder_seq_jp_io against a transaction-level model.
module tb_decoder_seq_jp_io;

  logic       clk = 1'b0;
  logic       notReset;
  logic [2:0] en;
  logic [7:0] Source, flags, accIn, dataIn;
  logic       busReady;

  logic        busy_v[3], memRead_v[3], pcInc_v[3], ioRead_v[3], ioWrite_v[3];
  logic [15:0] portAddr_v[3], pcLoadValue_v[3];
  logic [7:0]  ioData_v[3], accValue_v[3];
  logic        accLoad_v[3], pcLoad_v[3], done_v[3], unsupported_v[3];

  // instance 0: IO_WAIT=1, instance 1: IO_WAIT=3, instance 2: IO_WAIT=0 with I/O disabled
  localparam int IOW[3]   = '{1, 3, 0};
  localparam bit IO_EN[3] = '{1'b1, 1'b1, 1'b0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    decoder_seq_jp_io #(.IO_WAIT(IOW[g]), .ENABLE_IO(IO_EN[g])) u_dut (
      .clk         (clk),
      .notReset    (notReset),
      .enable      (en[g]),
      .Source      (Source),
      .flags       (flags),
      .accIn       (accIn),
      .dataIn      (dataIn),
      .busReady    (busReady),
      .busy        (busy_v[g]),
      .memRead     (memRead_v[g]),
      .pcInc       (pcInc_v[g]),
      .ioRead      (ioRead_v[g]),
      .ioWrite     (ioWrite_v[g]),
      .portAddr    (portAddr_v[g]),
      .ioData      (ioData_v[g]),
      .accLoad     (accLoad_v[g]),
      .accValue    (accValue_v[g]),
      .pcLoad      (pcLoad_v[g]),
      .pcLoadValue (pcLoadValue_v[g]),
      .done        (done_v[g]),
      .unsupported (unsupported_v[g])
    );
  end

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [56:0] out_vec(input int i);
    return {busy_v[i], memRead_v[i], pcInc_v[i], ioRead_v[i], ioWrite_v[i], portAddr_v[i],
            ioData_v[i], accLoad_v[i], accValue_v[i], pcLoad_v[i], pcLoadValue_v[i],
            done_v[i], unsupported_v[i]};
  endfunction

  // -1 outside the group, 0 JP nn, 1 JP cc, 2 OUT, 3 IN
  function automatic int kind_of(input logic [7:0] op);
    case (op)
      8'hC3, 8'hCB, 8'hE3, 8'hEB: return 0;
      8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA: return 1;
      8'hD3, 8'hF3: return 2;
      8'hDB, 8'hFB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit cond_true(input int cc, input logic [7:0] fl);
    case (cc)
      0: return !fl[6];
      1: return  fl[6];
      2: return !fl[0];
      3: return  fl[0];
      4: return !fl[2];
      5: return  fl[2];
      6: return !fl[7];
      default: return fl[7];
    endcase
  endfunction

  task automatic noise(input int i, input bit spur);
    flags = 8'($urandom);
    if (spur) begin
      en[i]  = 1'($urandom);
      Source = 8'($urandom);
    end
  endtask

  task automatic fetch(input int i, input logic [7:0] data, input int stalls, input bit spur);
    for (int s = 0; s < stalls; s++) begin
      busReady = 1'b0; dataIn = 8'($urandom); noise(i, spur);
      #1;
      chk("fetch_stall_mem", {busy_v[i], memRead_v[i], pcInc_v[i], done_v[i]}, 4'b1100);
      @(negedge clk);
    end
    busReady = 1'b1; dataIn = data; noise(i, spur);
    #1;
    chk("fetch_mem_pcinc", {busy_v[i], memRead_v[i], pcInc_v[i], done_v[i]}, 4'b1110);
    @(negedge clk);
  endtask

  task automatic run_op(input int i, input logic [7:0] op, lo, hi, fl, a, din,
                        input int st_lo, st_hi, st_x, input bit spur);
    int  k;
    bit  ok;
    bit  taken;
    k  = kind_of(op);
    ok = (k >= 0) && (k < 2 || IO_EN[i]);
    Source = op; en[i] = 1'b1; busReady = 1'($urandom); accIn = a; flags = 8'($urandom);
    #1;
    chk("idle_busy", busy_v[i], 0);
    chk("unsupported", unsupported_v[i], !ok);
    @(negedge clk);
    en[i] = 1'b0;
    if (!ok) begin
      #1;
      chk("reject_stays_idle", {busy_v[i], unsupported_v[i]}, 2'b00);
      return;
    end
    fetch(i, lo, st_lo, spur);
    if (k < 2) begin
      fetch(i, hi, st_hi, spur);
      flags = fl; busReady = 1'($urandom);
      if (spur) begin en[i] = 1'($urandom); Source = 8'($urandom); end
      taken = (k == 0) || cond_true(int'(op[5:3]), fl);
      #1;
      chk("exec_done", {done_v[i], memRead_v[i], busy_v[i]}, 3'b101);
      chk("exec_pcload", pcLoad_v[i], taken);
      chk("exec_target", pcLoadValue_v[i], {hi, lo});
      @(negedge clk);
    end else begin
      for (int w = 0; w < IOW[i]; w++) begin
        busReady = 1'($urandom); noise(i, spur);
        #1;
        chk("io_wait", {busy_v[i], memRead_v[i], ioRead_v[i], ioWrite_v[i], done_v[i]}, 5'b10000);
        @(negedge clk);
      end
      for (int s = 0; s <= st_x; s++) begin
        busReady = (s == st_x); dataIn = (s == st_x) ? din : 8'($urandom); noise(i, spur);
        #1;
        chk("xfer_dir", {ioRead_v[i], ioWrite_v[i]}, (k == 3) ? 2'b10 : 2'b01);
        chk("xfer_port", portAddr_v[i], {a, lo});
        chk("xfer_data", ioData_v[i], (k == 2) ? a : 8'h00);
        chk("xfer_done", {done_v[i], accLoad_v[i]}, {s == st_x, (s == st_x) && (k == 3)});
        if (s == st_x && k == 3) chk("xfer_accvalue", accValue_v[i], din);
        @(negedge clk);
      end
    end
    en[i] = 1'b0;
    #1;
    chk("after_done_idle", {busy_v[i], done_v[i]}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops[19];
    int         i;
    ops = '{8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA, 8'hC3, 8'hCB,
            8'hE3, 8'hEB, 8'hD3, 8'hF3, 8'hDB, 8'hFB, 8'hC3, 8'hD3, 8'hDB};
    notReset = 1'b0; en = 3'b000; Source = 8'h00; flags = 8'h00;
    accIn = 8'h00; dataIn = 8'h00; busReady = 1'b0;
    #3;
    for (int d = 0; d < 3; d++) chk("reset_outputs", out_vec(d), 0);
    @(negedge clk);
    notReset = 1'b1;

    run_op(0, 8'hC3, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0);
    run_op(0, 8'hCA, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0);
    run_op(0, 8'hCA, 8'h00, 8'h80, 8'h40, 8'h00, 8'h00, 0, 0, 0, 1'b0);
    run_op(0, 8'hDB, 8'h10, 8'h00, 8'h00, 8'h5A, 8'hAB, 0, 0, 0, 1'b0);
    run_op(0, 8'hD3, 8'hFE, 8'h00, 8'h00, 8'h77, 8'h00, 0, 0, 3, 1'b0);
    run_op(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0);
    run_op(2, 8'hDB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0);
    run_op(0, 8'hC3, 8'hCD, 8'hAB, 8'h00, 8'h00, 8'h00, 1, 2, 0, 1'b1);
    run_op(1, 8'hDB, 8'h33, 8'h00, 8'h00, 8'hC1, 8'h5E, 0, 0, 1, 1'b0);
    run_op(2, 8'hC2, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0);

    // reset asserted mid-cycle while in FETCH_HI
    Source = 8'hC3; en[0] = 1'b1; busReady = 1'b1;
    @(negedge clk);
    en[0] = 1'b0; dataIn = 8'h99;
    @(negedge clk);
    busReady = 1'b0;
    #1;
    chk("pre_reset_fetch_hi", memRead_v[0], 1);
    #2;
    notReset = 1'b0; en[0] = 1'b1; Source = 8'h00; busReady = 1'b1;
    #1;
    chk("async_reset_outputs", out_vec(0), 0);
    @(posedge clk);
    #1;
    chk("held_reset_outputs", out_vec(0), 0);
    @(negedge clk);
    notReset = 1'b1; en[0] = 1'b0;
    #1;
    chk("post_reset_idle", busy_v[0], 0);
    run_op(0, 8'hC3, 8'h78, 8'h56, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0);

    for (int t = 0; t < 250; t++) begin
      logic [7:0] op;
      i  = $urandom_range(0, 2);
      op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 18)] : 8'($urandom);
      run_op(i, op, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
             1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_seq_jp_io.md
# decoder_seq_jp_io

Sequenced execution controller for the 11ccc01x opcode group: JP nn (C3), JP cc,nn (C2/CA/D2/DA/E2/EA/F2/FA), OUT (n),A (D3), IN A,(n) (DB). Sits behind the phase-2 opcode decoder. It accepts one opcode byte, then runs the operand-fetch, condition-evaluation and I/O machine cycles with a ready handshake. It issues the PC, accumulator and bus strobes. It is the clocked, parametrised successor to the purely combinational P2_Set_* decode.

## Interface
Parameters:
- IO_WAIT, 1, extra wait cycles inserted before the I/O transfer (0..15).
- ENABLE_IO, 1, 0 rejects D3/DB as unsupported.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- notReset  input  1  asynchronous, active-low reset.
- enable  input  1  opcode-valid strobe, sampled in IDLE only.
- Source  input  8  opcode byte.
- flags  input  8  F register: S=7, Z=6, PV=2, C=0.
- accIn  input  8  current A.
- dataIn  input  8  bus read data.
- busReady  input  1  completes the current memory or I/O cycle.
- busy  output  1  high in every state except IDLE.
- memRead  output  1  operand fetch request.
- pcInc  output  1  memRead & busReady.
- ioRead, ioWrite  output  1  I/O cycle requests.
- portAddr  output  16  {accIn, n} during IO_XFER, else 0.
- ioData  output  8  accIn while ioWrite, else 0.
- accLoad  output  1  load A with accValue.
- accValue  output  8  captured IN data.
- pcLoad  output  1  jump taken.
- pcLoadValue  output  16  {hi, lo}.
- done  output  1  one-cycle completion pulse.
- unsupported  output  1  one-cycle reject pulse.

## Operation
- The group is matched by Source[7:6]=11 and Source[2:1]=01. Source[0]=0 selects JP cc, with ccc=Source[5:3]. Source[0]=1 decodes Source[4:3]: 0x selects JP nn, 10 selects OUT, 11 selects IN.
- Opcodes outside the group, and D3/DB when ENABLE_IO=0, pulse unsupported for 1 cycle and the block stays in IDLE.
- Condition codes: 0 NZ, 1 Z, 2 NC, 3 C, 4 PO (PV=0), 5 PE, 6 P (S=0), 7 M. JP nn is always taken.
- States:
  - IDLE: on an accepted enable, latch the opcode and go to FETCH_LO.
  - FETCH_LO: memRead=1. On busReady, capture lo and go to FETCH_HI for a jump. For I/O, go to IO_WAIT, or to IO_XFER if IO_WAIT=0.
  - FETCH_HI: memRead=1. On busReady, capture hi and go to EXEC.
  - EXEC: evaluate flags in this cycle. Assert pcLoad if taken, assert done, then go to IDLE. pcLoadValue={hi,lo} regardless of taken.
  - IO_WAIT: load the counter with IO_WAIT-1 on entry and decrement every cycle. Go to IO_XFER when it reaches 0.
  - IO_XFER: ioRead (IN) or ioWrite (OUT). On busReady, assert done. For IN, also assert accLoad with accValue=dataIn. Then go to IDLE.
- busReady low stalls FETCH_LO, FETCH_HI and IO_XFER indefinitely with all requests held. busReady is ignored in IDLE, EXEC and IO_WAIT.
- enable while busy is ignored and never queued.

## Timing
- Reset (notReset low, asynchronous): state returns to IDLE. All latches, the counter and every output go to 0, including mid-cycle. Outputs may be combinational from state but must be 0 while reset is held.
- Zero-wait cycle counts from enable to done:
  - JP: 4 cycles (IDLE, FETCH_LO, FETCH_HI, EXEC).
  - IN/OUT: 3+IO_WAIT cycles.
- After done, the next opcode may be accepted on the following cycle at the earliest.
- pcInc, accLoad, done and unsupported are single-cycle pulses.
- portAddr, ioRead and ioWrite are stable for the whole IO_XFER state.
- flags are sampled in EXEC only. A flag change during the fetches is irrelevant.

## Structure
- Package decoder_seq_pkg holds:
  - the state enum: IDLE, FETCH_LO, FETCH_HI, EXEC, IO_WAIT, IO_XFER;
  - the cc encodings;
  - the flag bit indices S_BIT, Z_BIT, PV_BIT, C_BIT;
  - the opcode group match mask.
- Sub-module decoder_cc_eval is combinational: (ccc, flags) -> taken.

## Test plan
- Opcode C3, operands 34,12, busReady=1: done at cycle 4, pcLoad=1, pcLoadValue=1234, pcInc pulsed twice.
- Opcode CA (JP Z) with flags=00 and operands 00,80: pcLoad=0 and done=1 at cycle 4. Repeat with flags=40: pcLoad=1, pcLoadValue=8000.
- Opcode DB, A=5A, n=10, IO_WAIT=1, dataIn=AB: ioRead with portAddr=5A10; accLoad=1, accValue=AB, done at cycle 4.
- Opcode D3, A=77, n=FE, busReady low for 3 cycles in IO_XFER: ioWrite, ioData=77, portAddr=77FE held throughout; done in the cycle busReady returns.
- Opcode 00, then DB with ENABLE_IO=0: unsupported pulses once each, busy stays 0. enable asserted during a JP has no effect.
- notReset asserted in FETCH_HI: all outputs are 0 immediately. After release the block is in IDLE and accepts C3 normally.
